// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver (uart_rx_reader and its sampler).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Clocks per bit period.
  function automatic int unsigned uart_scale(input int unsigned clk_mhz, input int unsigned boadrate);
    return (clk_mhz * 32'd1_000_000) / boadrate;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, bit-period down-counter and bit sampler for uart_rx_reader.
// With UART_RX_MAJORITY_EN defined each bit is a 2-of-3 vote of rx_s taken at cnt==2,1,0.
module uart_rx_sampler (
  input  logic        clk,
  input  logic        arstn,
  input  logic        rx,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        rx_s,
  output logic        bit_strobe,
  output logic        bit_value
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [31:0] cnt_q, cnt_d;

  // The counter rests at zero while idle; the FSM ignores the strobe there.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= 32'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_s       = sync2_q;
  assign bit_strobe = (cnt_q == 32'd0);

`ifdef UART_RX_MAJORITY_EN
  logic vote2_q, vote2_d;
  logic vote1_q, vote1_d;

  always_comb begin
    vote2_d = (cnt_q == 32'd2) ? sync2_q : vote2_q;
    vote1_d = (cnt_q == 32'd1) ? sync2_q : vote1_q;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      vote2_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      vote2_q <= vote2_d;
      vote1_q <= vote1_d;
    end
  end

  assign bit_value = (vote2_q & vote1_q) | (vote2_q & sync2_q) | (vote1_q & sync2_q);
`else
  assign bit_value = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_reader.sv
// 8N1 UART receiver with a valid/ready output holding register, framing-error and overrun pulses.
// Optional 2-of-3 majority bit sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned boadrate = 9600
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   rx,
  output logic                   valid,
  output logic [UART_DATA_W-1:0] data,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int unsigned SCALE    = uart_scale(clk_mhz, boadrate);
  localparam int unsigned HALF     = SCALE / 2;
  localparam logic [31:0] SCALE_M1 = 32'(SCALE - 1);
  localparam logic [31:0] HALF_M1  = 32'(HALF - 1);

  logic        rx_s, bit_strobe, bit_value;
  logic        load;
  logic [31:0] load_val;

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .arstn      (arstn),
    .rx         (rx),
    .load       (load),
    .load_val   (load_val),
    .rx_s       (rx_s),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value)
  );

  uart_rx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;
    load_val    = SCALE_M1;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          load     = 1'b1;
          load_val = HALF_M1;
        end
      end
      START: begin
        if (bit_strobe) begin
          if (!bit_value) begin
            state_d = DATA;
            idx_d   = 3'd0;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shreg_d = {bit_value, shreg_q[UART_DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          load    = 1'b1;
          if (idx_q == 3'(UART_DATA_W - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Back to IDLE at mid-stop-bit so the next start edge is not missed.
        if (bit_strobe) begin
          state_d = IDLE;
          if (!bit_value) begin
            frame_err_d = 1'b1;
          end else if (valid_q && !ready) begin
            overrun_d = 1'b1;
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= 3'd0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
